// File: rtl/alu_exec_unit_pkg.sv
// Shared ALU opcode and execute-FSM encodings, also used by the ALU control decoder.
package alu_exec_unit_pkg;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_MUL  = 2'b10;
  localparam logic [1:0] ALU_OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_mul_pipe.sv
// Pipelined unsigned multiplier: operands captured on start, product emerges
// MUL_LATENCY-1 cycles later so the caller's output register lands at MUL_LATENCY.
module alu_mul_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             valid,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned STAGES = MUL_LATENCY - 1;

  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  mul_lo;
  logic [STAGES-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (start) begin
      a_q <= op_a;
      b_q <= op_b;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= start;
      for (int i = 1; i < int'(STAGES); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign mul_lo = a_q * b_q;
  assign valid  = vld_q[STAGES-1];

  if (STAGES == 1) begin : g_direct
    assign product = mul_lo;
  end else begin : g_staged
    // Data stages carry no reset; only the valid chain decides what is live.
    logic [WIDTH-1:0] prod_q [STAGES-1];

    always_ff @(posedge clk) begin
      prod_q[0] <= mul_lo;
      for (int i = 1; i < int'(STAGES) - 1; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end

    assign product = prod_q[STAGES-2];
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle add/sub, pipelined mul, registered result with
// valid/ready handshake, zero flag for branch compare and a destination tag.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned TAG_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic             set_nop,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             accept, issue, issue_mul;
  logic             mul_valid, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] addsub_res;

  assign in_ready  = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign issue     = accept && !set_nop;
  assign issue_mul = issue && (alu_op == ALU_OP_MUL);
  assign mul_done  = (state_q == ST_MUL) && mul_valid && (cnt_q == CNT_ONE);

  always_comb begin
    addsub_res = '0;
    case (alu_op)
      ALU_OP_ADD: addsub_res = op_a + op_b;
      ALU_OP_SUB: addsub_res = op_a + ~op_b + WIDTH'(1);
      default:    addsub_res = '0;
    endcase
  end

  alu_mul_pipe #(
    .WIDTH       (WIDTH),
    .MUL_LATENCY (MUL_LATENCY)
  ) u_mul_pipe (
    .clk     (clk),
    .clear   (reset || flush),
    .start   (issue_mul),
    .op_a    (op_a),
    .op_b    (op_b),
    .valid   (mul_valid),
    .product (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    tag_d    = tag_q;

    unique case (state_q)
      ST_IDLE: ;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      ST_MUL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (mul_done) begin
          state_d  = ST_HOLD;
          result_d = mul_product;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // New work only arrives in IDLE or in HOLD while the held result drains.
    if (issue) begin
      tag_d = in_tag;
      if (issue_mul) begin
        state_d = ST_MUL;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d  = ST_HOLD;
        result_d = addsub_res;
      end
    end

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign out_result = result_q;
  assign out_zero   = (result_q == '0);
  assign out_tag    = tag_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
